// File: rtl/snake_pkg.sv
// Shared constants for the snake game-step sequencer: directions, FSM codes, grid defaults.
package snake_pkg;

    localparam int GRID_W_D = 40;
    localparam int GRID_H_D = 30;
    localparam int X_W_D    = 6;
    localparam int Y_W_D    = 5;

    localparam int unsigned TICK_INIT_D = 32'd25_000_000;
    localparam int unsigned TICK_STEP_D = 32'd2_000_000;
    localparam int unsigned TICK_MIN_D  = 32'd5_000_000;
    localparam int          LEVEL_MAX_D = 7;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        CHECK = 3'd2,
        MOVE  = 3'd3,
        DEAD  = 3'd4
    } state_e;

    function automatic logic [3:0] dir_opposite(input logic [3:0] d);
        logic [3:0] o;
        case (d)
            DIR_UP:    o = DIR_DOWN;
            DIR_DOWN:  o = DIR_UP;
            DIR_LEFT:  o = DIR_RIGHT;
            DIR_RIGHT: o = DIR_LEFT;
            default:   o = 4'b0000;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/snake_move_ctrl_if.sv
// Collision-check handshake between the move sequencer (master) and the body store (slave).
interface snake_move_ctrl_if #(
    parameter int X_W = 6,
    parameter int Y_W = 5
);
    logic           chk_req;
    logic           chk_ack;
    logic           chk_hit;
    logic [X_W-1:0] nxt_x;
    logic [Y_W-1:0] nxt_y;

    modport master (output chk_req, nxt_x, nxt_y, input chk_ack, chk_hit);
    modport slave  (input chk_req, nxt_x, nxt_y, output chk_ack, chk_hit);
endinterface

// File: rtl/snake_move_ctrl_step_timer.sv
// Level-paced step timer: counts RUN cycles and flags the cycle that ends the current period.
module step_timer #(
    parameter int unsigned TICK_INIT = 32'd25_000_000,
    parameter int unsigned TICK_STEP = 32'd2_000_000,
    parameter int unsigned TICK_MIN  = 32'd5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic [2:0] level_i,
    output logic       due_o
);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] dec;
    logic [31:0] period;

    // Clamp before subtracting so a large level never wraps the period.
    always_comb begin
        dec = 32'(level_i) * TICK_STEP;
        if ((TICK_INIT > dec) && ((TICK_INIT - dec) > TICK_MIN))
            period = TICK_INIT - dec;
        else
            period = TICK_MIN;
    end

    // >= keeps the timer safe if the period shrinks while already counting.
    assign due_o = en_i && (cnt_q >= (period - 32'd1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake game-step sequencer: paces the head, latches one legal direction per step,
// checks walls locally and body collisions via the body store, and keeps score/level.
module snake_move_ctrl
    import snake_pkg::*;
#(
    parameter int          GRID_W    = GRID_W_D,
    parameter int          GRID_H    = GRID_H_D,
    parameter int          X_W       = X_W_D,
    parameter int          Y_W       = Y_W_D,
    parameter int unsigned TICK_INIT = TICK_INIT_D,
    parameter int unsigned TICK_STEP = TICK_STEP_D,
    parameter int unsigned TICK_MIN  = TICK_MIN_D,
    parameter int          LEVEL_MAX = LEVEL_MAX_D
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [3:0]             direction,
    input  logic [X_W-1:0]         food_x,
    input  logic [Y_W-1:0]         food_y,
    snake_move_ctrl_if.master      chk,
    output logic [X_W-1:0]         head_x,
    output logic [Y_W-1:0]         head_y,
    output logic                   move_step,
    output logic                   grow,
    output logic                   dead,
    output logic [2:0]             state,
    output logic [7:0]             score,
    output logic [2:0]             level
);

    localparam logic [X_W-1:0] X_C   = X_W'(GRID_W / 2);
    localparam logic [Y_W-1:0] Y_C   = Y_W'(GRID_H / 2);
    localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);

    state_e         st_q, st_d;
    logic [X_W-1:0] hx_q, hx_d, nx_q, nx_d, cx;
    logic [Y_W-1:0] hy_q, hy_d, ny_q, ny_d, cy;
    logic [3:0]     dir_q, dir_d, dir_sel;
    logic           req_q, req_d, mv_q, mv_d, gr_q, gr_d;
    logic [7:0]     score_q, score_d;
    logic [2:0]     level_q, level_d;
    logic           step_due, legal, wall;

    step_timer #(
        .TICK_INIT (TICK_INIT),
        .TICK_STEP (TICK_STEP),
        .TICK_MIN  (TICK_MIN)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (st_q == RUN),
        .clr_i   (st_d != RUN),
        .level_i (level_q),
        .due_o   (step_due)
    );

    // Candidate cell uses the direction that would be latched this cycle.
    always_comb begin
        legal   = $onehot(direction) && (direction != dir_opposite(dir_q));
        dir_sel = legal ? direction : dir_q;
        cx      = hx_q;
        cy      = hy_q;
        wall    = 1'b0;
        case (dir_sel)
            DIR_UP:    begin wall = (hy_q == '0);    cy = hy_q - Y_W'(1); end
            DIR_DOWN:  begin wall = (hy_q == Y_MAX); cy = hy_q + Y_W'(1); end
            DIR_LEFT:  begin wall = (hx_q == '0);    cx = hx_q - X_W'(1); end
            DIR_RIGHT: begin wall = (hx_q == X_MAX); cx = hx_q + X_W'(1); end
            default:   ;
        endcase
    end

    always_comb begin
        st_d    = st_q;
        hx_d    = hx_q;
        hy_d    = hy_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        dir_d   = dir_q;
        score_d = score_q;
        req_d   = 1'b0;
        mv_d    = 1'b0;
        gr_d    = 1'b0;
        unique case (st_q)
            IDLE: begin
                hx_d    = X_C;
                hy_d    = Y_C;
                dir_d   = DIR_DOWN;
                score_d = '0;
                if (start) st_d = RUN;
            end
            RUN: begin
                if (step_due) begin
                    dir_d = dir_sel;
                    if (wall) begin
                        st_d = DEAD;
                    end else begin
                        nx_d  = cx;
                        ny_d  = cy;
                        req_d = 1'b1;
                        st_d  = CHECK;
                    end
                end
            end
            CHECK: begin
                req_d = 1'b1;
                if (chk.chk_ack) begin
                    req_d = 1'b0;
                    if (chk.chk_hit) begin
                        st_d = DEAD;
                    end else begin
                        st_d = MOVE;
                        hx_d = nx_q;
                        hy_d = ny_q;
                        mv_d = 1'b1;
                        if ((nx_q == food_x) && (ny_q == food_y)) begin
                            gr_d = 1'b1;
                            if (score_q != 8'hFF) score_d = score_q + 8'd1;
                        end
                    end
                end
            end
            MOVE: st_d = RUN;
            DEAD: begin
                // Centre the head on the way out so IDLE shows reset values at once.
                if (start) begin
                    st_d    = IDLE;
                    hx_d    = X_C;
                    hy_d    = Y_C;
                    dir_d   = DIR_DOWN;
                    score_d = '0;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        if (score_q[7:2] > 6'(LEVEL_MAX))
            level_d = 3'(LEVEL_MAX);
        else
            level_d = score_q[4:2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            hx_q    <= X_C;
            hy_q    <= Y_C;
            nx_q    <= '0;
            ny_q    <= '0;
            dir_q   <= DIR_DOWN;
            req_q   <= 1'b0;
            mv_q    <= 1'b0;
            gr_q    <= 1'b0;
            score_q <= '0;
            level_q <= '0;
        end else begin
            st_q    <= st_d;
            hx_q    <= hx_d;
            hy_q    <= hy_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            dir_q   <= dir_d;
            req_q   <= req_d;
            mv_q    <= mv_d;
            gr_q    <= gr_d;
            score_q <= score_d;
            level_q <= level_d;
        end
    end

    assign chk.chk_req = req_q;
    assign chk.nxt_x   = nx_q;
    assign chk.nxt_y   = ny_q;
    assign head_x      = hx_q;
    assign head_y      = hy_q;
    assign move_step   = mv_q;
    assign grow        = gr_q;
    assign dead        = (st_q == DEAD);
    assign state       = st_q;
    assign score       = score_q;
    assign level       = level_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl with short tick periods and a latency-programmable body-store model.
module tb_snake_move_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] direction;
    logic [5:0] food_x, head_x;
    logic [4:0] food_y, head_y;
    logic       move_step, grow, dead;
    logic [2:0] state, level;
    logic [7:0] score;

    int n_vec = 0;
    int n_err = 0;
    int lat = 3;
    logic hit_cfg = 1'b0;
    int wcnt;
    // RUN periods per level for TICK_INIT=10, TICK_STEP=2, TICK_MIN=4
    int per_tbl [5] = '{10, 8, 6, 4, 4};

    snake_move_ctrl_if #(.X_W(6), .Y_W(5)) chk_if ();

    snake_move_ctrl #(
        .TICK_INIT (10),
        .TICK_STEP (2),
        .TICK_MIN  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .direction (direction),
        .food_x    (food_x),
        .food_y    (food_y),
        .chk       (chk_if),
        .head_x    (head_x),
        .head_y    (head_y),
        .move_step (move_step),
        .grow      (grow),
        .dead      (dead),
        .state     (state),
        .score     (score),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Body-store model: one-cycle ack on the lat-th edge after seeing chk_req.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_if.chk_ack <= 1'b0;
            chk_if.chk_hit <= 1'b0;
            wcnt           <= 0;
        end else begin
            chk_if.chk_ack <= 1'b0;
            chk_if.chk_hit <= 1'b0;
            if (chk_if.chk_req && !chk_if.chk_ack) begin
                if (wcnt == lat - 1) begin
                    chk_if.chk_ack <= 1'b1;
                    chk_if.chk_hit <= hit_cfg;
                    wcnt           <= 0;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    task automatic expect_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return chk_if.chk_req;
            1:       return move_step;
            default: return dead;
        endcase
    endfunction

    // Counts negedges until the selected output is seen high; timeout counts as a miscompare.
    task automatic wait_for(input int sel, input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(sel) && n < lim);
        if (!sig(sel)) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout sel=%0d: got none after %0d cycles, want event", sel, n);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        logic rq, bad_nxt, bad_mv;
        logic [5:0] sx;
        logic [4:0] sy;
        int ex, ey;

        rst_n = 1'b0; start = 1'b0; direction = 4'b0100; food_x = '0; food_y = '0;
        repeat (3) @(negedge clk);
        expect_eq("rst_state", state, 0);
        expect_eq("rst_hx", head_x, 20);
        expect_eq("rst_hy", head_y, 15);
        expect_eq("rst_req", chk_if.chk_req, 0);
        expect_eq("rst_dead", dead, 0);
        expect_eq("rst_score", score, 0);
        expect_eq("rst_level", level, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First step straight down
        pulse_start();
        wait_for(0, 40, n);
        expect_eq("first_req_lat", n, 10);
        expect_eq("first_nx", chk_if.nxt_x, 20);
        expect_eq("first_ny", chk_if.nxt_y, 16);
        wait_for(1, 40, n);
        expect_eq("first_move_lat", n, 4);
        expect_eq("first_hx", head_x, 20);
        expect_eq("first_hy", head_y, 16);
        expect_eq("first_grow", grow, 0);

        // Reverse and non-one-hot directions are ignored
        direction = 4'b1000;
        wait_for(0, 40, n);
        expect_eq("rev_ny", chk_if.nxt_y, 17);
        wait_for(1, 40, n);
        direction = 4'b0011;
        wait_for(0, 40, n);
        expect_eq("multi_nx", chk_if.nxt_x, 20);
        expect_eq("multi_ny", chk_if.nxt_y, 18);
        wait_for(1, 40, n);

        // Turn right and run into the east wall
        direction = 4'b0001;
        for (int i = 0; i < 19; i++) begin
            wait_for(0, 40, n);
            expect_eq("right_nx", chk_if.nxt_x, 21 + i);
            expect_eq("right_ny", chk_if.nxt_y, 18);
            wait_for(1, 40, n);
        end
        expect_eq("edge_hx", head_x, 39);
        n = 0; rq = 1'b0;
        do begin @(negedge clk); n++; rq |= chk_if.chk_req; end while (!dead && n < 40);
        expect_eq("wall_dead", dead, 1);
        expect_eq("wall_lat", n, 11);
        expect_eq("wall_noreq", rq, 0);
        expect_eq("wall_state", state, 4);
        repeat (3) @(negedge clk);
        expect_eq("dead_frozen_hx", head_x, 39);

        // DEAD -> IDLE -> RUN needs two starts
        pulse_start();
        expect_eq("idle_state", state, 0);
        expect_eq("idle_hx", head_x, 20);
        expect_eq("idle_hy", head_y, 15);
        expect_eq("idle_dead", dead, 0);
        repeat (5) @(negedge clk);
        expect_eq("idle_hold", state, 0);

        // Eat an apple every step: 4 down, then right; intervals shrink with level
        direction = 4'b0100; food_x = 6'd20; food_y = 5'd16;
        pulse_start();
        expect_eq("restart_state", state, 1);
        ex = 20; ey = 15;
        for (int s = 1; s <= 16; s++) begin
            if (s <= 4) begin direction = 4'b0100; ey++; end
            else begin direction = 4'b0001; ex++; end
            food_x = 6'(ex); food_y = 5'(ey);
            wait_for(0, 40, n);
            expect_eq("food_interval", n, per_tbl[(s - 1) >> 2] + (s == 1 ? 0 : 1));
            expect_eq("food_nx", chk_if.nxt_x, ex);
            expect_eq("food_ny", chk_if.nxt_y, ey);
            wait_for(1, 40, n);
            expect_eq("food_grow", grow, 1);
            expect_eq("food_score", score, s);
        end
        @(negedge clk);
        expect_eq("lvl4_level", level, 4);
        food_x = '0; food_y = '0;

        // Collision: hit after 7 cycles
        lat = 7; hit_cfg = 1'b1;
        wait_for(0, 40, n);
        sx = chk_if.nxt_x; sy = chk_if.nxt_y;
        expect_eq("hit_nx", sx, 33);
        expect_eq("hit_ny", sy, 19);
        n = 0; bad_nxt = 1'b0; bad_mv = 1'b0;
        do begin
            @(negedge clk); n++;
            if (chk_if.chk_req && (chk_if.nxt_x != sx || chk_if.nxt_y != sy)) bad_nxt = 1'b1;
            bad_mv |= move_step;
        end while (!dead && n < 40);
        expect_eq("hit_dead", dead, 1);
        expect_eq("hit_lat", n, 8);
        expect_eq("hit_nxt_stable", bad_nxt, 0);
        expect_eq("hit_no_move", bad_mv, 0);
        expect_eq("hit_hx", head_x, 32);
        expect_eq("hit_req_drop", chk_if.chk_req, 0);

        // Asynchronous reset in the middle of CHECK
        lat = 3; hit_cfg = 1'b0;
        pulse_start();
        pulse_start();
        wait_for(0, 40, n);
        expect_eq("rc_req_lat", n, 10);
        @(negedge clk);
        expect_eq("rc_in_check", state, 2);
        rst_n = 1'b0;
        #1;
        expect_eq("rc_req", chk_if.chk_req, 0);
        expect_eq("rc_state", state, 0);
        expect_eq("rc_hx", head_x, 20);
        expect_eq("rc_hy", head_y, 15);
        expect_eq("rc_move", move_step, 0);
        expect_eq("rc_dead", dead, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
